// File: rtl/arb_pkg.sv
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and helpers for the round-robin priority arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/prio_pick.sv
// ============================================================================
// Module      : prio_pick
// Description : Combinational highest-set-bit finder with a rotating start point.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_pick
    import arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int IDXW = clog2_min1(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IDXW-1:0] start_i,
    output logic [IDXW-1:0] idx_o,
    output logic            found_o
);

    logic [N-1:0] w_rot;
    int           w_pos;
    int           w_sum;

    // Rotate so that start_i lands on bit N-1, take the highest set bit, then map back.
    always_comb begin
        w_rot = '0;
        w_pos = 0;
        w_sum = 0;
        for (int j = 0; j < N; j++) begin
            w_rot[j] = req_i[(j + int'(start_i) + 1) % N];
        end
        for (int j = 0; j < N; j++) begin
            if (w_rot[j]) begin
                w_pos = j;
            end
        end
        w_sum = w_pos + int'(start_i) + 1;
        if (w_sum >= N) begin
            w_sum = w_sum - N;
        end
        idx_o   = IDXW'(w_sum);
        found_o = |req_i;
    end

endmodule

`default_nettype wire

// File: rtl/priority_arbiter_rr.sv
// ============================================================================
// Module      : priority_arbiter_rr
// Description : Registered N-way arbiter, fixed or round-robin, valid/ready grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module priority_arbiter_rr
    import arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int IDXW = clog2_min1(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            mode,
    input  logic            gnt_ready,
    output logic            gnt_valid,
    output logic [IDXW-1:0] gnt_idx,
    output logic [N-1:0]    gnt_onehot
);

    localparam logic [IDXW-1:0] C_TOP_IDX = IDXW'(N - 1);

    arb_state_e      state_q;
    arb_state_e      state_d;
    logic [IDXW-1:0] rr_ptr_q;
    logic [IDXW-1:0] rr_ptr_d;
    logic [IDXW-1:0] idx_q;
    logic [IDXW-1:0] idx_d;
    logic [N-1:0]    onehot_q;
    logic [N-1:0]    onehot_d;

    logic            w_accept;
    logic            w_arb;
    logic            w_found;
    logic [IDXW-1:0] w_start;
    logic [IDXW-1:0] w_pick_idx;

    assign w_accept = (state_q == ARB_GRANT) && gnt_ready;
    assign w_arb    = w_found && ((state_q == ARB_IDLE) || w_accept);

    // The pointer advances on a round-robin accept and the same-edge pick already uses it.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_accept && (mode == MODE_RR)) begin
            rr_ptr_d = (idx_q == '0) ? C_TOP_IDX : (idx_q - IDXW'(1));
        end
    end

    assign w_start = (mode == MODE_RR) ? rr_ptr_d : C_TOP_IDX;

    prio_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .req_i   (req),
        .start_i (w_start),
        .idx_o   (w_pick_idx),
        .found_o (w_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (w_found) begin
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (gnt_ready && !w_found) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        idx_d    = idx_q;
        onehot_d = onehot_q;
        if (w_arb) begin
            idx_d    = w_pick_idx;
            onehot_d = N'(1) << w_pick_idx;
        end else if (w_accept) begin
            idx_d    = '0;
            onehot_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= C_TOP_IDX;
            idx_q    <= '0;
            onehot_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
        end
    end

    always_comb begin
        gnt_valid  = (state_q == ARB_GRANT);
        gnt_idx    = idx_q;
        gnt_onehot = onehot_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_priority_arbiter_rr.sv
// ============================================================================
// Module      : tb_priority_arbiter_rr
// Description : Self-checking bench for priority_arbiter_rr at N=4, 8 and 2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_priority_arbiter_rr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] req;
    logic        mode;
    logic        gnt_ready;
    bit          chk_en = 1'b0;
    int          total  = 0;
    int          bad    = 0;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_arb
        localparam int NN = (g == 0) ? 4 : ((g == 1) ? 8 : 2);
        localparam int IW = $clog2(NN);

        logic          v;
        logic [IW-1:0] ix;
        logic [NN-1:0] oh;
        logic [31:0]   ix32;
        logic [31:0]   oh32;
        int            mv;
        int            midx;
        int            mptr;
        int            mr;
        int            mpick;

        assign ix32 = 32'(ix);
        assign oh32 = 32'(oh);

        priority_arbiter_rr #(.N(NN)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req        (req[NN-1:0]),
            .mode       (mode),
            .gnt_ready  (gnt_ready),
            .gnt_valid  (v),
            .gnt_idx    (ix),
            .gnt_onehot (oh)
        );

        // Reference: grant state as plain integers, search order straight from the rules.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mv   = 0;
                midx = 0;
                mptr = NN - 1;
            end else if (mv == 0 || gnt_ready) begin
                if (mv != 0 && mode) begin
                    mptr = (midx == 0) ? NN - 1 : midx - 1;
                end
                mr    = int'(req[NN-1:0]);
                mpick = -1;
                for (int k = 0; k < NN; k++) begin
                    if (mode) begin
                        if (mpick < 0 && mr[(mptr - k + NN) % NN]) mpick = (mptr - k + NN) % NN;
                    end else begin
                        if (mr[k]) mpick = k;
                    end
                end
                if (mpick >= 0) begin
                    mv   = 1;
                    midx = mpick;
                end else begin
                    mv   = 0;
                    midx = 0;
                end
            end
        end

        always @(negedge clk) begin
            if (chk_en && rst_n) begin
                check_eq($sformatf("N%0d valid", NN), 32'(v), 32'(mv));
                if (mv != 0) check_eq($sformatf("N%0d idx", NN), ix32, 32'(midx));
                check_eq($sformatf("N%0d onehot", NN), oh32, (mv != 0) ? (32'd1 << midx) : 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #1 rst_n = 1'b0;
        #1;
        check_eq("async rst valid", 32'(g_arb[0].v), 32'd0);
        check_eq("async rst onehot", g_arb[0].oh32, 32'd0);
        #1 rst_n = 1'b1;
    endtask

    int seq_a[6] = '{3, 2, 1, 0, 3, 2};
    int seq_b[4] = '{1, 3, 1, 3};

    initial begin
        rst_n     = 1'b0;
        req       = 32'hF;
        mode      = 1'b0;
        gnt_ready = 1'b0;
        step();
        step();
        chk_en = 1'b1;
        check_eq("reset valid", 32'(g_arb[0].v), 32'd0);
        check_eq("reset idx", g_arb[0].ix32, 32'd0);
        check_eq("reset onehot", g_arb[0].oh32, 32'd0);

        rst_n = 1'b1;
        step();
        check_eq("first grant valid", 32'(g_arb[0].v), 32'd1);
        check_eq("first grant idx", g_arb[0].ix32, 32'd3);

        req       = 32'h7;
        gnt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("fixed idx", g_arb[0].ix32, 32'd2);
            check_eq("fixed onehot", g_arb[0].oh32, 32'h4);
            check_eq("fixed valid", 32'(g_arb[0].v), 32'd1);
        end

        req = 32'h0;
        pulse_reset();
        mode = 1'b1;
        req  = 32'hF;
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("rr all idx", g_arb[0].ix32, 32'(seq_a[i]));
        end
        req = 32'hA;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("rr 1010 idx", g_arb[0].ix32, 32'(seq_b[i]));
        end

        req = 32'h0;
        step();
        check_eq("accept idle valid", 32'(g_arb[0].v), 32'd0);
        step();
        check_eq("ready in idle", 32'(g_arb[0].v), 32'd0);

        mode      = 1'b0;
        req       = 32'h1;
        gnt_ready = 1'b0;
        step();
        check_eq("bp first idx", g_arb[0].ix32, 32'd0);
        req = 32'h8;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("bp hold idx", g_arb[0].ix32, 32'd0);
        end
        gnt_ready = 1'b1;
        step();
        check_eq("bp release idx", g_arb[0].ix32, 32'd3);
        gnt_ready = 1'b0;

        mode = 1'b1;
        step();
        check_eq("mode toggle idx", g_arb[0].ix32, 32'd3);
        mode = 1'b0;
        step();
        check_eq("mode toggle back idx", g_arb[0].ix32, 32'd3);
        pulse_reset();

        mode      = 1'b1;
        req       = 32'hFF;
        gnt_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            check_eq("n8 wrap idx", g_arb[1].ix32, (k == 8) ? 32'd7 : 32'(7 - k));
            check_eq("n2 alt idx", g_arb[2].ix32, (k % 2 == 0) ? 32'd1 : 32'd0);
        end

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       req = 32'h0;
                1:       req = 32'd1 << $urandom_range(0, 7);
                default: req = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            gnt_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) pulse_reset();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
